// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO.
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam int UART_DEF_DEPTH = 16;

   // Increment an 8-bit counter, holding at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO: Depth x 8.
// One synchronous write port and one asynchronous read port.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter  int Depth = UART_DEF_DEPTH,
   localparam int AW    = $clog2(Depth)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  uart_byte_t      i_wdata,
   input  logic [AW-1:0]   i_raddr,
   output uart_byte_t      o_rdata
);

   uart_byte_t r_mem [Depth];

   // Write port; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: turns rxDone rising edges into byte pushes, buffers
// them, and reports occupancy plus sticky overflow / framing-error flags.
// Optional: define UART_RX_FIFO_STATS_EN to add saturating dropCount and
// errCount outputs.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int Depth           = UART_DEF_DEPTH,
   parameter int AlmostFullLevel = Depth - 4
) (
   input  logic                    clk,
   input  logic                    nReset,
   input  uart_byte_t              rxData,
   input  logic                    rxDone,
   input  logic                    rxErr,
   output uart_byte_t              outData,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [$clog2(Depth):0]  count,
   output logic                    almostFull,
   output logic                    overflow,
   output logic                    frameErr,
   input  logic                    clrFlags
`ifdef UART_RX_FIFO_STATS_EN
   ,
   output logic [7:0]              dropCount,
   output logic [7:0]              errCount
`endif
);

   localparam int AW = $clog2(Depth);

   logic [AW:0] r_wptr, r_rptr;
   logic        r_done_d, r_armed, r_pend, r_wr;
   uart_byte_t  r_wdata;

   logic        w_rise, w_empty, w_full, w_pop, w_push, w_drop;
   logic [AW:0] w_count;
   uart_byte_t  w_rdata;

   // r_armed stays low after reset until rxDone is seen low, so a done
   // level held across reset release cannot masquerade as a new edge.
   assign w_rise   = rxDone & ~r_done_d & r_armed;
   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop    = ~w_empty & outReady;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push   = r_wr & (~w_full | w_pop);
   assign w_drop   = r_wr & w_full & ~w_pop;
   assign w_count  = r_wptr - r_rptr;

   assign count      = w_count;
   assign outValid   = ~w_empty;
   assign outData    = w_empty ? '0 : w_rdata;
   assign almostFull = (int'(w_count) >= AlmostFullLevel);

   // Edge detect and two-stage push pipeline: edge -> sample data -> write.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_done_d <= 1'b0;
         r_armed  <= 1'b0;
         r_pend   <= 1'b0;
         r_wr     <= 1'b0;
         r_wdata  <= '0;
      end else begin
         r_done_d <= rxDone;
         r_armed  <= r_armed | ~rxDone;
         r_pend   <= w_rise & ~rxErr;
         r_wr     <= r_pend;
         if (r_pend) r_wdata <= rxData;
      end
   end

   // Read/write pointers, one extra MSB to tell full from empty.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Sticky flags; a setting event beats a simultaneous clear.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         overflow <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         overflow <= (overflow & ~clrFlags) | w_drop;
         frameErr <= (frameErr & ~clrFlags) | rxErr;
      end
   end

`ifdef UART_RX_FIFO_STATS_EN
   logic r_err_d;

   // Saturating event counters, zeroed by clrFlags.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_err_d   <= 1'b0;
         dropCount <= '0;
         errCount  <= '0;
      end else begin
         r_err_d <= rxErr;
         if (clrFlags) begin
            dropCount <= '0;
            errCount  <= '0;
         end else begin
            if (w_drop)            dropCount <= sat_inc8(dropCount);
            if (rxErr && !r_err_d) errCount  <= sat_inc8(errCount);
         end
      end
   end
`endif

   uart_fifo_mem #(.Depth(Depth)) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wptr[AW-1:0]),
      .i_wdata (r_wdata),
      .i_raddr (r_rptr[AW-1:0]),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (Depth = 16).
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       nReset = 1'b0;
   logic [7:0] rxData = 8'h00;
   logic       rxDone = 1'b0;
   logic       rxErr = 1'b0;
   logic       outReady = 1'b0;
   logic       clrFlags = 1'b0;
   logic [7:0] outData;
   logic       outValid;
   logic [4:0] count;
   logic       almostFull;
   logic       overflow;
   logic       frameErr;
`ifdef UART_RX_FIFO_STATS_EN
   logic [7:0] dropCount;
   logic [7:0] errCount;
`endif

   int total = 0;
   int bad   = 0;

   uart_rx_fifo #(.Depth(16)) dut (
      .clk        (clk),
      .nReset     (nReset),
      .rxData     (rxData),
      .rxDone     (rxDone),
      .rxErr      (rxErr),
      .outData    (outData),
      .outValid   (outValid),
      .outReady   (outReady),
      .count      (count),
      .almostFull (almostFull),
      .overflow   (overflow),
      .frameErr   (frameErr),
      .clrFlags   (clrFlags)
`ifdef UART_RX_FIFO_STATS_EN
      ,
      .dropCount  (dropCount),
      .errCount   (errCount)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle rxDone pulse; returns on the negedge before the write.
   task automatic send_byte(input logic [7:0] b);
      rxData = b;
      rxDone = 1'b1;
      @(negedge clk);
      rxDone = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_one();
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outValid); end
      total++; if (outData !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", outData); end
      total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almostFull); end
      total++; if ({overflow, frameErr} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, frameErr}); end
      nReset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int n = 0;
      rxData = 8'hA5;
      rxDone = 1'b1;
      do begin
         @(negedge clk);
         n++;
         rxDone = 1'b0;
      end while (!outValid && n < 6);
      total++; if (n > 3) begin bad++; $display("FAIL single_latency got=%0d exp<=3 negedges", n); end
      total++; if (outData !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", outData); end
      total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
      pop_one();
      total++; if (count !== 5'd0 || outValid !== 1'b0) begin bad++; $display("FAIL single_pop count=%0d valid=%b exp=0/0", count, outValid); end
      pop_one();
      total++; if (count !== 5'd0) begin bad++; $display("FAIL empty_pop count=%0d exp=0", count); end
   endtask

   task automatic test_hold();
      rxData = 8'h3C;
      rxDone = 1'b1;
      repeat (10) @(negedge clk);
      rxDone = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", count); end
      total++; if (outData !== 8'h3C) begin bad++; $display("FAIL hold_data got=%h exp=3c", outData); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      for (int i = 0; i < 17; i++) begin
         send_byte(8'h10 + 8'(i));
         if (i == 10) begin
            repeat (2) @(negedge clk);
            total++; if (count !== 5'd11 || almostFull !== 1'b0) begin bad++; $display("FAIL afull_11 count=%0d af=%b exp=11/0", count, almostFull); end
         end
         if (i == 11) begin
            repeat (2) @(negedge clk);
            total++; if (count !== 5'd12 || almostFull !== 1'b1) begin bad++; $display("FAIL afull_12 count=%0d af=%b exp=12/1", count, almostFull); end
         end
      end
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      total++; if (outData !== 8'h10) begin bad++; $display("FAIL ovf_head got=%h exp=10", outData); end
      for (int k = 0; k < 16; k++) begin
         exp = 8'h10 + 8'(k);
         total++; if (outData !== exp) begin bad++; $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, outData, exp); end
         pop_one();
      end
      total++; if (outValid !== 1'b0) begin bad++; $display("FAIL ovf_17th valid=%b exp=0", outValid); end
      clrFlags = 1'b1;
      @(negedge clk);
      clrFlags = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] exp;
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_fill got=%0d exp=16", count); end
      rxData = 8'h99;
      rxDone = 1'b1;
      @(negedge clk);
      rxDone = 1'b0;
      total++; if (outData !== 8'h20) begin bad++; $display("FAIL pp_oldest got=%h exp=20", outData); end
      @(negedge clk);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
      total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_count got=%0d exp=16", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
      for (int k = 1; k < 16; k++) begin
         exp = 8'h20 + 8'(k);
         total++; if (outData !== exp) begin bad++; $display("FAIL pp_drain k=%0d got=%h exp=%h", k, outData, exp); end
         pop_one();
      end
      total++; if (outData !== 8'h99) begin bad++; $display("FAIL pp_last got=%h exp=99", outData); end
      pop_one();
      total++; if (outValid !== 1'b0) begin bad++; $display("FAIL pp_empty valid=%b exp=0", outValid); end
   endtask

   task automatic test_err_clr();
      rxErr = 1'b1;
      @(negedge clk);
      rxErr = 1'b0;
      total++; if (frameErr !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", frameErr); end
      @(negedge clk);
      rxErr = 1'b1;
      @(negedge clk);
`ifdef UART_RX_FIFO_STATS_EN
      total++; if (errCount !== 8'd2) begin bad++; $display("FAIL err_cnt2 got=%0d exp=2", errCount); end
`endif
      clrFlags = 1'b1;
      @(negedge clk);
      rxErr = 1'b0;
      clrFlags = 1'b0;
      total++; if (frameErr !== 1'b1) begin bad++; $display("FAIL err_setwins got=%b exp=1", frameErr); end
`ifdef UART_RX_FIFO_STATS_EN
      total++; if (errCount !== 8'd0) begin bad++; $display("FAIL err_cnt0 got=%0d exp=0", errCount); end
`endif
      clrFlags = 1'b1;
      @(negedge clk);
      clrFlags = 1'b0;
      total++; if (frameErr !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", frameErr); end
      rxData = 8'h77;
      rxDone = 1'b1;
      rxErr  = 1'b1;
      @(negedge clk);
      rxDone = 1'b0;
      rxErr  = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL err_nopush count=%0d exp=0", count); end
      clrFlags = 1'b1;
      @(negedge clk);
      clrFlags = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd5) begin bad++; $display("FAIL rst_fill got=%0d exp=5", count); end
      rxData = 8'h55;
      rxDone = 1'b1;
      @(posedge clk);
      #1 nReset = 1'b0;
      @(negedge clk);
      total++; if (count !== 5'd0 || outValid !== 1'b0) begin bad++; $display("FAIL rst_mid count=%0d valid=%b exp=0/0", count, outValid); end
      total++; if (outData !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h exp=00", outData); end
      @(negedge clk);
      nReset = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_held_done count=%0d exp=0", count); end
      rxDone = 1'b0;
      @(negedge clk);
      rxDone = 1'b1;
      @(negedge clk);
      rxDone = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (count !== 5'd1 || outData !== 8'h55) begin bad++; $display("FAIL rst_rearm count=%0d data=%h exp=1/55", count, outData); end
      pop_one();
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_overflow();
      test_full_pushpop();
      test_err_clr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
